// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Holds FSM encodings, the frame sync byte and the baud divisor helper.
package uart_imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_CNT,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_imem_loader_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, framing check.
// Emits a one-cycle o_valid with o_byte and o_ferr (stop bit sampled low).
module uart_imem_loader_rx
  import uart_imem_loader_pkg::*;
#(
  parameter int DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rxd,
  output logic       o_valid,
  output logic [7:0] o_byte,
  output logic       o_ferr
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] C_HALF = CW'(DIV / 2 - 1);

  logic [1:0]    r_sync;
  logic          r_prev;
  rx_state_t     r_st, w_st;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bit, w_bit;
  logic [7:0]    r_shift, w_shift;
  logic          r_valid, w_valid;
  logic          r_ferr, w_ferr;
  logic          w_rx;

  assign w_rx = r_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_prev  <= 1'b1;
      r_st    <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_rxd};
      r_prev  <= w_rx;
      r_st    <= w_st;
      r_cnt   <= w_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
    end
  end

  // Start needs a high-to-low edge so a low stop bit cannot retrigger.
  always_comb begin
    w_st    = r_st;
    w_cnt   = r_cnt + CW'(1);
    w_bit   = r_bit;
    w_shift = r_shift;
    w_valid = 1'b0;
    w_ferr  = r_ferr;
    unique case (r_st)
      RX_IDLE: begin
        w_cnt = '0;
        if (r_prev && !w_rx) w_st = RX_START;
      end
      RX_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt = '0;
          w_bit = '0;
          w_st  = w_rx ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_cnt == C_FULL) begin
          w_cnt   = '0;
          w_shift = {w_rx, r_shift[7:1]};
          w_bit   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_st = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_cnt == C_FULL) begin
          w_valid = 1'b1;
          w_ferr  = ~w_rx;
          w_st    = RX_IDLE;
        end
      end
      default: w_st = RX_IDLE;
    endcase
  end

  assign o_valid = r_valid;
  assign o_byte  = r_shift;
  assign o_ferr  = r_ferr;

endmodule

// File: rtl/uart_imem_loader.sv
// Serial program loader: parses A5/N/data/xor frames from UART into IMem.
// Holds the CPU in reset while a frame is being received.
module uart_imem_loader
  import uart_imem_loader_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BAUD        = 115200,
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input  logic              clk,
  input  logic              cpu_resetn,
  input  logic              load_en,
  input  logic              uart_rxd,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic [1:0]        r_rst;
  logic              w_rst_n;
  logic              w_rx_valid;
  logic [7:0]        w_rx_byte;
  logic              w_rx_ferr;
  logic              w_active;
  logic              w_sync_ok;

  ld_state_t         r_st, w_st;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [ADDR_W:0]   r_wcnt, w_wcnt;
  logic [ADDR_W:0]   r_n, w_n;
  logic [31:0]       r_word, w_word;
  logic [1:0]        r_bidx, w_bidx;
  logic [7:0]        r_csum, w_csum;
  logic              r_done, w_done;
  logic              r_err, w_err;
  logic              r_hold, w_hold;
  logic              r_we, w_we;
  logic [TW-1:0]     r_tmo, w_tmo;

  // Reset asserts immediately, releases two clocks later.
  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) r_rst <= 2'b00;
    else             r_rst <= {r_rst[0], 1'b1};
  end
  assign w_rst_n = r_rst[1];

  uart_imem_loader_rx #(
    .DIV(baud_div(CLK_HZ, BAUD))
  ) u_rx (
    .clk    (clk),
    .rst_n  (w_rst_n),
    .i_rxd  (uart_rxd),
    .o_valid(w_rx_valid),
    .o_byte (w_rx_byte),
    .o_ferr (w_rx_ferr)
  );

  assign w_active  = r_st inside {ST_CNT, ST_DATA, ST_WRITE, ST_CSUM};
  assign w_sync_ok = w_rx_valid && !w_rx_ferr && (w_rx_byte == SYNC_BYTE);

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_st   <= ST_IDLE;
      r_addr <= '0;
      r_wcnt <= '0;
      r_n    <= '0;
      r_word <= '0;
      r_bidx <= '0;
      r_csum <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_hold <= 1'b0;
      r_we   <= 1'b0;
      r_tmo  <= '0;
    end else begin
      r_st   <= w_st;
      r_addr <= w_addr;
      r_wcnt <= w_wcnt;
      r_n    <= w_n;
      r_word <= w_word;
      r_bidx <= w_bidx;
      r_csum <= w_csum;
      r_done <= w_done;
      r_err  <= w_err;
      r_hold <= w_hold;
      r_we   <= w_we;
      r_tmo  <= w_tmo;
    end
  end

  always_comb begin
    w_st   = r_st;
    w_addr = r_addr;
    w_wcnt = r_wcnt;
    w_n    = r_n;
    w_word = r_word;
    w_bidx = r_bidx;
    w_csum = r_csum;
    w_done = r_done;
    w_err  = r_err;
    w_we   = 1'b0;
    w_tmo  = '0;
    unique case (r_st)
      ST_IDLE: if (load_en) w_st = ST_SYNC;
      ST_SYNC, ST_DONE, ST_ERR: begin
        if (w_sync_ok) begin
          w_st   = ST_CNT;
          w_done = 1'b0;
          w_err  = 1'b0;
          w_wcnt = '0;
          w_addr = '0;
        end
      end
      ST_CNT: begin
        if (w_rx_valid) begin
          w_n    = (w_rx_byte == 8'd0) ? (ADDR_W+1)'(256)
                                       : (ADDR_W+1)'(w_rx_byte);
          w_bidx = '0;
          w_csum = '0;
          w_st   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_rx_valid) begin
          w_word = {r_word[23:0], w_rx_byte};
          w_csum = r_csum ^ w_rx_byte;
          w_bidx = r_bidx + 2'd1;
          if (r_bidx == 2'd3) begin
            w_st = ST_WRITE;
            w_we = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        w_addr = r_addr + ADDR_W'(1);
        w_wcnt = r_wcnt + (ADDR_W+1)'(1);
        w_st   = (w_wcnt == r_n) ? ST_CSUM : ST_DATA;
      end
      ST_CSUM: begin
        if (w_rx_valid) begin
          if (w_rx_byte == r_csum) begin
            w_st   = ST_DONE;
            w_done = 1'b1;
          end else begin
            w_st  = ST_ERR;
            w_err = 1'b1;
          end
        end
      end
      default: w_st = ST_IDLE;
    endcase
    if (w_active) w_tmo = w_rx_valid ? '0 : r_tmo + TW'(1);
    if (w_active && ((w_rx_valid && w_rx_ferr) || r_tmo == T_LAST)) begin
      w_st   = ST_ERR;
      w_err  = 1'b1;
      w_done = 1'b0;
      w_we   = 1'b0;
    end
    if (r_st != ST_IDLE && !load_en) begin
      w_st = ST_IDLE;
      w_we = 1'b0;
      if (w_active) w_err = 1'b1;
    end
    w_hold = w_st inside {ST_SYNC, ST_CNT, ST_DATA, ST_WRITE, ST_CSUM};
  end

  assign im_we     = r_we;
  assign im_addr   = r_addr;
  assign im_wdata  = r_word;
  assign cpu_hold  = r_hold;
  assign load_done = r_done;
  assign load_err  = r_err;
  assign word_cnt  = r_wcnt;

endmodule
